// File: rtl/lives_score_tracker.sv
// Score, lives and invulnerability bookkeeping feeding the game-flow FSM.
// Optional HIGH_SCORE_EN macro builds the best-score register; otherwise it is tied to zero.
module lives_score_tracker #(
  parameter int START_LIVES   = 3,
  parameter int LIVES_W       = 2,
  parameter int INVULN_FRAMES = 90,
  parameter int FRAME_CNT_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_frame_tick,
  input  logic               i_alien_hit,
  input  logic [1:0]         i_alien_pts,
  input  logic               i_player_hit,
  input  logic               i_invader_landed,
  output logic [15:0]        o_score_bcd,
  output logic [LIVES_W-1:0] o_lives,
  output logic               o_invulnerable,
  output logic               o_finished,
  output logic [15:0]        o_high_score_bcd
);

  typedef enum logic [1:0] {S_IDLE, S_PLAYING, S_RESPAWN, S_OVER} state_t;

  state_t                 r_state, w_state_next;
  logic [15:0]            r_score, w_score_next;
  logic [LIVES_W-1:0]     r_lives, w_lives_next;
  logic [FRAME_CNT_W-1:0] r_cnt, w_cnt_next;
  logic                   r_invuln, r_finished;

  // BCD add into the tens digit; ones digit is always zero.
  logic [3:0]  w_tens, w_tens_d, w_hund, w_hund_d, w_thou;
  logic        w_c1, w_c2, w_ovf;
  logic [15:0] w_score_add;

  always_comb begin
    w_tens      = r_score[7:4] + {2'b00, i_alien_pts};
    w_c1        = (w_tens > 4'd9);
    w_tens_d    = w_c1 ? (w_tens - 4'd10) : w_tens;
    w_hund      = r_score[11:8] + {3'b000, w_c1};
    w_c2        = (w_hund > 4'd9);
    w_hund_d    = w_c2 ? 4'd0 : w_hund;
    w_thou      = r_score[15:12] + {3'b000, w_c2};
    w_ovf       = (w_thou > 4'd9);
    w_score_add = w_ovf ? 16'h9990 : {w_thou, w_hund_d, w_tens_d, 4'h0};
  end

  always_comb begin
    w_state_next = r_state;
    w_score_next = r_score;
    w_lives_next = r_lives;
    w_cnt_next   = r_cnt;
    if (i_start) begin
      w_state_next = S_PLAYING;
      w_score_next = 16'h0000;
      w_lives_next = LIVES_W'(START_LIVES);
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_PLAYING: begin
          if (i_alien_hit) w_score_next = w_score_add;
          if (i_invader_landed) begin
            w_state_next = S_OVER;
            w_lives_next = '0;
          end else if (i_player_hit) begin
            if (r_lives <= LIVES_W'(1)) begin
              w_state_next = S_OVER;
              w_lives_next = '0;
            end else begin
              w_state_next = S_RESPAWN;
              w_lives_next = r_lives - LIVES_W'(1);
              w_cnt_next   = FRAME_CNT_W'(INVULN_FRAMES);
            end
          end
        end
        S_RESPAWN: begin
          if (i_alien_hit) w_score_next = w_score_add;
          if (i_invader_landed) begin
            w_state_next = S_OVER;
            w_lives_next = '0;
          end else if (i_frame_tick) begin
            w_cnt_next = r_cnt - FRAME_CNT_W'(1);
            if (r_cnt <= FRAME_CNT_W'(1)) w_state_next = S_PLAYING;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_score    <= 16'h0000;
      r_lives    <= LIVES_W'(START_LIVES);
      r_cnt      <= '0;
      r_invuln   <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_score    <= w_score_next;
      r_lives    <= w_lives_next;
      r_cnt      <= w_cnt_next;
      r_invuln   <= (w_state_next == S_RESPAWN);
      r_finished <= (w_state_next == S_OVER);
    end
  end

`ifdef HIGH_SCORE_EN
  logic [15:0] r_high;

  // BCD values compare correctly as plain unsigned numbers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_high <= 16'h0000;
    end else if ((w_state_next == S_OVER) && (r_state != S_OVER) && (w_score_next > r_high)) begin
      r_high <= w_score_next;
    end
  end

  assign o_high_score_bcd = r_high;
`else
  assign o_high_score_bcd = 16'h0000;
`endif

  assign o_score_bcd    = r_score;
  assign o_lives        = r_lives;
  assign o_invulnerable = r_invuln;
  assign o_finished     = r_finished;

endmodule

// File: tb/tb_lives_score_tracker.sv
// Scoreboard bench for lives_score_tracker: expected snapshots are queued as stimulus
// is driven and compared against the outputs one cycle later.
module tb_lives_score_tracker;

`ifdef HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, frame_tick, alien_hit, player_hit, invader_landed;
  logic [1:0]  alien_pts;
  logic [15:0] score_bcd, high_score_bcd;
  logic [1:0]  lives;
  logic        invulnerable, finished;

  lives_score_tracker dut (
    .clk(clk), .reset(reset), .i_start(start), .i_frame_tick(frame_tick),
    .i_alien_hit(alien_hit), .i_alien_pts(alien_pts), .i_player_hit(player_hit),
    .i_invader_landed(invader_landed), .o_score_bcd(score_bcd), .o_lives(lives),
    .o_invulnerable(invulnerable), .o_finished(finished), .o_high_score_bcd(high_score_bcd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] score;
    logic [1:0]  lives;
    logic        inv;
    logic        fin;
    logic [15:0] high;
  } snap_t;

  snap_t exp_q[$];
  string tag_q[$];
  snap_t got, want;
  string tag;
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model: score kept as an integer count of tens.
  int   m_tens, m_lives, m_high;
  logic m_inv, m_fin;

  function automatic logic [15:0] to_bcd(input int tens);
    return {4'(tens / 100), 4'((tens / 10) % 10), 4'(tens % 10), 4'h0};
  endfunction

  function automatic snap_t observe();
    snap_t s;
    s.score = score_bcd; s.lives = lives; s.inv = invulnerable;
    s.fin = finished; s.high = high_score_bcd;
    return s;
  endfunction

  function automatic void push(input string t);
    snap_t s;
    s.score = to_bcd(m_tens); s.lives = 2'(m_lives); s.inv = m_inv;
    s.fin = m_fin; s.high = HS ? to_bcd(m_high) : 16'h0000;
    exp_q.push_back(s);
    tag_q.push_back(t);
  endfunction

  function automatic void add_pts(input int p);
    m_tens = (m_tens + p > 999) ? 999 : m_tens + p;
  endfunction

  function automatic void game_over();
    m_fin = 1'b1; m_inv = 1'b0; m_lives = 0;
    if (m_tens > m_high) m_high = m_tens;
  endfunction

  task automatic drive(input logic st, input logic ft, input logic ah, input logic [1:0] pts,
                       input logic ph, input logic il);
    start = st; frame_tick = ft; alien_hit = ah; alien_pts = pts;
    player_hit = ph; invader_landed = il;
    @(posedge clk); #1;
    start = 1'b0; frame_tick = 1'b0; alien_hit = 1'b0; alien_pts = 2'd0;
    player_hit = 1'b0; invader_landed = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_tens = 0; m_lives = 3; m_inv = 0; m_fin = 0; m_high = 0;
    push("reset");
    drive(0, 0, 0, 2'd0, 0, 0);
    reset = 1'b0;
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    push("idle_ignores_events");
    drive(0, 1, 1, 2'd3, 1, 1);
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
  endtask

  task automatic test_scoring();
    logic [1:0] pts_tab [6] = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2};
    m_tens = 0; m_lives = 3; m_inv = 0; m_fin = 0;
    push("start");
    drive(1, 0, 0, 2'd0, 0, 0);
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    for (int i = 0; i < 6; i++) begin
      add_pts(int'(pts_tab[i]));
      push($sformatf("score_add_%0d", i));
      drive(0, 0, 1, pts_tab[i], 0, 0);
      got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] pts_tab [4] = '{2'd2, 2'd2, 2'd3, 2'd1};
    m_tens = 0; m_lives = 3; m_inv = 0; m_fin = 0;
    drive(1, 0, 0, 2'd0, 0, 0);
    for (int i = 0; i < 332; i++) begin
      add_pts(3);
      push("ramp");
      drive(0, 0, 1, 2'd3, 0, 0);
      got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    end
    for (int i = 0; i < 4; i++) begin
      add_pts(int'(pts_tab[i]));
      push($sformatf("saturate_%0d", i));
      drive(0, 0, 1, pts_tab[i], 0, 0);
      got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    end
  endtask

  task automatic test_respawn();
    m_tens = 0; m_lives = 3; m_inv = 0; m_fin = 0;
    drive(1, 0, 0, 2'd0, 0, 0);
    m_lives = 2; m_inv = 1;
    push("first_hit");
    drive(0, 0, 0, 2'd0, 1, 0);
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 2'd0, 0, 0);
    push("hit_masked");
    drive(0, 0, 0, 2'd0, 1, 0);
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    add_pts(2);
    push("score_in_respawn");
    drive(0, 0, 1, 2'd2, 0, 0);
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    for (int i = 0; i < 85; i++) begin
      if (i == 84) m_inv = 0;
      push($sformatf("tick_%0d", i + 6));
      drive(0, 1, 0, 2'd0, 0, 0);
      got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    end
  endtask

  task automatic test_fatal_simul();
    m_lives = 1; m_inv = 1;
    push("second_hit");
    drive(0, 0, 0, 2'd0, 1, 0);
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    for (int i = 0; i < 90; i++) drive(0, 1, 0, 2'd0, 0, 0);
    m_inv = 0;
    push("respawn_over");
    drive(0, 0, 0, 2'd0, 0, 0);
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    add_pts(1);
    game_over();
    push("fatal_hit_with_score");
    drive(0, 0, 1, 2'd1, 1, 0);
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    push("over_holds");
    drive(0, 1, 1, 2'd3, 1, 1);
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
  endtask

  task automatic test_landed_restart();
    m_tens = 0; m_lives = 3; m_inv = 0; m_fin = 0;
    push("restart");
    drive(1, 0, 0, 2'd0, 0, 0);
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    add_pts(1);
    game_over();
    push("landed_beats_hit");
    drive(0, 0, 1, 2'd1, 1, 1);
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    m_tens = 0; m_lives = 3; m_fin = 0;
    push("start_wins");
    drive(1, 0, 1, 2'd3, 0, 1);
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    m_lives = 2; m_inv = 1;
    drive(0, 0, 0, 2'd0, 1, 0);
    game_over();
    push("landed_in_respawn");
    drive(0, 1, 0, 2'd0, 0, 1);
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
  endtask

  task automatic test_high_score();
    int game_len [2] = '{5, 4};
    reset = 1'b1;
    m_tens = 0; m_lives = 3; m_inv = 0; m_fin = 0; m_high = 0;
    drive(0, 0, 0, 2'd0, 0, 0);
    reset = 1'b0;
    for (int g = 0; g < 2; g++) begin
      m_tens = 0; m_lives = 3; m_fin = 0;
      drive(1, 0, 0, 2'd0, 0, 0);
      for (int i = 0; i < game_len[g]; i++) begin
        add_pts(3);
        drive(0, 0, 1, 2'd3, 0, 0);
      end
      game_over();
      push($sformatf("game_%0d_end", g + 1));
      drive(0, 0, 0, 2'd0, 0, 1);
      got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
    end
    drive(1, 0, 0, 2'd0, 0, 0);
    drive(0, 0, 1, 2'd3, 0, 0);
    reset = 1'b1;
    m_tens = 0; m_lives = 3; m_inv = 0; m_fin = 0; m_high = 0;
    push("reset_mid_game");
    drive(0, 0, 1, 2'd3, 0, 0);
    reset = 1'b0;
    got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s: got %h expected %h", tag, got, want); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; alien_hit = 1'b0; alien_pts = 2'd0;
    player_hit = 1'b0; invader_landed = 1'b0;
    test_reset();
    test_scoring();
    test_saturation();
    test_respawn();
    test_fatal_simul();
    test_landed_restart();
    test_high_score();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
